mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter.sv | 69 ++++++
 tb/tb_mux4_rr_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter for a 4:1 mux with per-owner grant quantum and a break-before-make gap
module mux4_rr_arbiter #(
    parameter int QUANTUM = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       enbl,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [3:0] LAST = 4'(QUANTUM - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] owner;
    logic [3:0] cnt;
    logic [1:0] win;
    logic       done;

    // first requester at or after ptr, scanning upward modulo 4
    always_comb begin
        win = ptr;
        for (int k = 3; k >= 0; k--)
            win = req[ptr + 2'(k)] ? ptr + 2'(k) : win;
        done = !req[owner] || cnt == LAST || !en;
    end

    // arbitration FSM with registered mux controls; s keeps the last owner while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
            gnt   <= '0;
            s     <= '0;
            enbl  <= 1'b0;
            busy  <= 1'b0;
        end else if (state == GRANT) begin
            if (done) begin
                state <= GAP;
                ptr   <= owner + 2'd1;
                gnt   <= '0;
                enbl  <= 1'b0;
                busy  <= 1'b0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end else if (en && req != 4'd0) begin
            state <= GRANT;
            owner <= win;
            cnt   <= '0;
            gnt   <= 4'b0001 << win;
            s     <= win;
            enbl  <= 1'b1;
            busy  <= 1'b1;
        end else begin
            state <= IDLE;
            gnt   <= '0;
            enbl  <= 1'b0;
            busy  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench comparing the arbiter against a cycle-level reference model
module tb_mux4_rr_arbiter;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] req = 4'd0;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       enbl;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] expq[$];

    int         m_holder = -1;
    int         m_held = 0;
    int         m_prio = 0;
    logic [1:0] m_s = 2'd0;

    logic rec = 1'b0;
    logic prev_enbl = 1'b0;
    int   owners[$];
    int   hi_count = 0;

    mux4_rr_arbiter #(.QUANTUM(Q)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt), .s(s), .enbl(enbl), .busy(busy)
    );

    always #5 clk = ~clk;

    // reference: who holds the mux after the coming edge, from the arbitration rules
    task automatic model(input logic r, input logic e, input logic [3:0] rq, output logic [7:0] exp_o);
        if (r) begin
            m_holder = -1;
            m_held   = 0;
            m_prio   = 0;
            m_s      = 2'd0;
        end else if (m_holder >= 0) begin
            if (!rq[m_holder] || m_held == Q || !e) begin
                m_prio   = (m_holder + 1) % 4;
                m_holder = -1;
            end else begin
                m_held++;
            end
        end else if (e && rq != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_holder < 0 && rq[(m_prio + k) % 4]) m_holder = (m_prio + k) % 4;
            end
            m_held = 1;
            m_s    = 2'(m_holder);
        end
        exp_o = {(m_holder >= 0) ? 4'(1 << m_holder) : 4'd0, m_s,
                 m_holder >= 0, m_holder >= 0};
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] rq);
        logic [7:0] x;
        @(negedge clk);
        rst = r;
        en  = e;
        req = rq;
        model(r, e, rq, x);
        expq.push_back(x);
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // monitor: every cycle the DUT presents its registered outputs; pop and compare
    initial begin
        logic [7:0] w;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (expq.size() > 0) begin
                w = expq.pop_front();
                total++;
                if ({gnt, s, enbl, busy} !== w) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got gnt=%b s=%b enbl=%b busy=%b want gnt=%b s=%b enbl=%b busy=%b",
                             cyc, gnt, s, enbl, busy, w[7:4], w[3:2], w[1], w[0]);
                end
            end
            if (rec) begin
                if (enbl && !prev_enbl) owners.push_back(int'(s));
                if (enbl) hi_count++;
            end
            prev_enbl = enbl;
        end
    end

    initial begin
        // single request, then drop it
        step(1, 0, 4'b0000);
        step(0, 1, 4'b0100);
        step(0, 1, 4'b0100);
        step(0, 1, 4'b0000);
        step(0, 1, 4'b0000);

        // rotation with all requesting from reset
        step(1, 0, 4'b0000);
        @(posedge clk);
        #2;
        owners.delete();
        rec = 1'b1;
        for (int i = 0; i < 40; i++) step(0, 1, 4'b1111);
        @(posedge clk);
        #2;
        rec = 1'b0;
        for (int i = 0; i < 5; i++)
            check("rotation_owner", i < owners.size() ? owners[i] : -1, i % 4);

        // sole requester quantum pattern
        step(1, 0, 4'b0000);
        @(posedge clk);
        #2;
        owners.delete();
        hi_count = 0;
        rec = 1'b1;
        for (int i = 0; i < 18; i++) step(0, 1, 4'b0001);
        @(posedge clk);
        #2;
        rec = 1'b0;
        check("sole_high_cycles", hi_count, 2 * Q);
        check("sole_grant_count", owners.size(), 2);

        // no preemption, pointer wraps from 3 to 0
        step(1, 0, 4'b0000);
        step(0, 1, 4'b1000);
        for (int i = 0; i < 3; i++) step(0, 1, 4'b1001);
        for (int i = 0; i < 4; i++) step(0, 1, 4'b0001);

        // en dropped mid-grant
        step(1, 0, 4'b0000);
        for (int i = 0; i < 3; i++) step(0, 1, 4'b0010);
        for (int i = 0; i < 4; i++) step(0, 0, 4'b1111);
        step(0, 1, 4'b1111);

        // reset mid-grant with owner 2 and cnt 5
        step(1, 0, 4'b0000);
        for (int i = 0; i < 6; i++) step(0, 1, 4'b0100);
        step(1, 1, 4'b0100);
        for (int i = 0; i < 4; i++) step(0, 1, 4'b1111);

        // randomized traffic
        begin
            logic [3:0] rq = 4'd0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
                step($urandom_range(0, 199) == 0, $urandom_range(0, 15) != 0, rq);
            end
        end

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
